// File: rtl/mcdf_chnl_slave.sv
// rtl/mcdf_chnl_slave.sv - MCDF per-channel ingress FIFO between initiator and arbiter
// Show-ahead FIFO: head word is presented combinationally from registered state.
module mcdf_chnl_slave #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          slv_en,
  input  logic          ch_valid,
  input  logic [DW-1:0] ch_data,
  output logic          ch_ready,
  input  logic          a2s_ack,
  output logic          slv_val,
  output logic          slv_req,
  output logic [DW-1:0] slv_data,
  output logic [AW:0]   margin
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_active;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full/empty come from the occupancy counter so pointer wrap needs no extra bit.
  assign w_active = !rst && slv_en;
  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);

  assign ch_ready = w_active && !w_full;
  assign slv_val  = w_active && !w_empty;
  assign slv_req  = slv_val;
  assign w_push   = ch_valid && ch_ready;
  assign w_pop    = a2s_ack && slv_val;

  assign slv_data = (!rst && !w_empty) ? r_mem[r_rd_ptr] : '0;
  assign margin   = rst ? DEPTH_C : (DEPTH_C - r_count);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ch_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_count_range : assert property (@(posedge clk) disable iff (rst) r_count <= DEPTH_C);
  a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst) !(w_pop && w_empty));

endmodule
